shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 126 ++++++++++++
 tb/tb_shift_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// Multi-cycle shifter: one power-of-two shift stage per clock (sll/srl/sra/pass).
// Define SHIFT_SKIP_EN to finish right after the highest set movement bit instead of always running 5 stages.
module shift_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] movement,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid and its payload stay stable until that edge, ready never depends on valid.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] OP_SLL  = 2'd0;
  localparam logic [1:0] OP_SRL  = 2'd1;
  localparam logic [1:0] OP_SRA  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;

`ifdef SHIFT_SKIP_EN
  localparam logic SKIP_EN = 1'b1;
`else
  localparam logic SKIP_EN = 1'b0;
`endif

  logic [1:0]  state;
  logic [2:0]  k;
  logic [31:0] w;
  logic [4:0]  mv;
  logic [1:0]  op_q;

  logic [7:0]  mv_ext;
  logic [4:0]  amt;
  logic [31:0] step_w;
  logic        last_stage;
  logic        sat;
  logic        imm;
  logic [31:0] imm_val;

  assign mv_ext = {3'b000, mv};
  assign amt    = 5'd1 << k;

  always_comb begin
    step_w = w;
    if (mv_ext[k]) begin
      case (op_q)
        OP_SLL:  step_w = w << amt;
        OP_SRL:  step_w = w >> amt;
        OP_SRA:  step_w = 32'($signed(w) >>> amt);
        default: step_w = w;
      endcase
    end
  end

  // In the skip build the sequence ends once no higher movement bit remains.
  always_comb begin
    if (SKIP_EN) last_stage = (mv_ext >> (k + 3'd1)) == 8'd0;
    else         last_stage = (k == 3'd4);
  end

  // Operations that complete straight from the accept edge.
  always_comb begin
    sat     = |movement[31:5];
    imm     = (op == OP_PASS) || sat || (SKIP_EN && (movement[4:0] == 5'd0));
    imm_val = a;
    if (op != OP_PASS && sat) imm_val = (op == OP_SRA) ? {32{a[31]}} : 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= 3'd0;
      w     <= 32'd0;
      mv    <= 5'd0;
      op_q  <= OP_SLL;
      out   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w    <= a;
            mv   <= movement[4:0];
            op_q <= op;
            k    <= 3'd0;
            if (imm) begin
              out   <= imm_val;
              state <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          w <= step_w;
          if (last_stage) begin
            out   <= step_w;
            k     <= 3'd0;
            state <= DONE;
          end else begin
            k <= k + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed vector table, backpressure/reset
// sequences, and random operations scored against an arithmetic reference model.
module tb_shift_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] movement;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        busy;
  logic [1:0]  dbg_state;

`ifdef SHIFT_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  shift_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .movement(movement), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: whole-word shifts by the full amount.
  function automatic logic [31:0] model_out(input logic [31:0] ma, input logic [31:0] mm,
                                            input logic [1:0] mo);
    if (mo == 2'd3) return ma;
    if (mm >= 32) return (mo == 2'd2) ? {32{ma[31]}} : 32'd0;
    case (mo)
      2'd0:    return ma << mm;
      2'd1:    return ma >> mm;
      default: return 32'($signed(ma) >>> mm);
    endcase
  endfunction

  function automatic int model_lat(input logic [31:0] mm, input logic [1:0] mo);
    int hi;
    if (mo == 2'd3 || mm >= 32) return 1;
    if (!SKIP) return 6;
    if (mm == 0) return 1;
    hi = 0;
    for (int i = 0; i < 5; i++) if (mm[i]) hi = i;
    return hi + 2;
  endfunction

  // Driver: issue one op (caller is 1ns after a rising edge), wait for the
  // result, hold backpressure for 'hold' cycles, then drain it.
  task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tm,
                        input logic [1:0] to, input int hold,
                        output logic [31:0] got, output int lat);
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    a = ta; movement = tm; op = to; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; movement = $urandom; op = 2'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got = out;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (hold > 0) check({name, "_hold_out"}, out, got);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_drained"}, {30'd0, busy, out_valid}, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] va;
    logic [31:0] vm;
    logic [1:0]  vo;
    logic [31:0] exp_out;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] got;
    int lat;
    logic [31:0] ra, rm;
    logic [1:0]  ro;

    vecs[0] = '{"sll31",     32'h0000_0001, 32'd31, 2'd0, 32'h8000_0000, 6};
    vecs[1] = '{"sra4",      32'hF000_0000, 32'd4,  2'd2, 32'hFF00_0000, SKIP ? 4 : 6};
    vecs[2] = '{"srl4",      32'hF000_0000, 32'd4,  2'd1, 32'h0F00_0000, SKIP ? 4 : 6};
    vecs[3] = '{"sat_sll",   32'h8000_0001, 32'h20, 2'd0, 32'h0000_0000, 1};
    vecs[4] = '{"sat_srl",   32'h8000_0001, 32'h20, 2'd1, 32'h0000_0000, 1};
    vecs[5] = '{"sat_sra",   32'h8000_0001, 32'h20, 2'd2, 32'hFFFF_FFFF, 1};
    vecs[6] = '{"pass",      32'h1234_5678, 32'd7,  2'd3, 32'h1234_5678, 1};
    vecs[7] = '{"mv0",       32'hDEAD_BEEF, 32'd0,  2'd0, 32'hDEAD_BEEF, SKIP ? 1 : 6};
    vecs[8] = '{"srl2",      32'h0000_0080, 32'd2,  2'd1, 32'h0000_0020, SKIP ? 3 : 6};
    vecs[9] = '{"sll1",      32'h0000_0001, 32'd1,  2'd0, 32'h0000_0002, SKIP ? 2 : 6};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; movement = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 32'd0);
    check("reset_flags", {30'd0, busy, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // directed table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].name, vecs[i].va, vecs[i].vm, vecs[i].vo, 0, got, lat);
      check({vecs[i].name, "_out"}, got, vecs[i].exp_out);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
    end

    // backpressure with ignored in_valid pulses, and no accept on the release edge
    a = 32'hF000_0000; movement = 32'd4; op = 2'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_reached_done", {31'd0, out_valid}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; movement = $urandom_range(0, 31); op = 2'($urandom);
      @(posedge clk); #1;
      check("bp_out", out, 32'hFF00_0000);
      check("bp_flags", {30'd0, out_valid, in_ready}, 32'd2);
    end
    in_valid = 1'b1; a = 32'h1; movement = 32'd1; op = 2'd0; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_release_no_accept", {30'd0, busy, in_ready}, 32'd1);

    // asynchronous reset during stage k=2
    a = 32'h0000_0001; movement = 32'd31; op = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_state_shift", {30'd0, dbg_state}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out", out, 32'd0);
    check("rst_mid_flags", {30'd0, busy, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 32'hF000_0000, 32'd4, 2'd1, 0, got, lat);
    check("after_rst_out", got, 32'h0F00_0000);

    // random operations against the reference model
    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      rm = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 31));
      ro = 2'($urandom_range(0, 3));
      exp_q.push_back(model_out(ra, rm, ro));
      run_op("rand", ra, rm, ro, $urandom_range(0, 3), got, lat);
      check("rand_out", got, exp_q.pop_front());
      check("rand_lat", 32'(lat), 32'(model_lat(rm, ro)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
